// File: rtl/complement_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : complement_display_pkg
// Description : Shared display mode enum, segment constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package complement_display_pkg;

    typedef enum logic [1:0] {
        MODE_ORIG   = 2'd0,
        MODE_ONES   = 2'd1,
        MODE_TWOS   = 2'd2,
        MODE_SIGNED = 2'd3
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low gfedcba pattern for decimal digits 0-9.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Decimal digits needed to hold the largest unsigned w-bit value.
    function automatic int bcd_nibbles(input int w);
        longint unsigned m;
        int              n;
        m = (64'd1 << w) - 64'd1;
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Multi-cycle shift-add-3 binary to BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W  = 10,
    parameter int NB = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    operand,
    output logic            busy,
    output logic            done,
    output logic [4*NB-1:0] bcd
);

    localparam int c_cw = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [4*NB-1:0]   r_bcd, w_bcd_nx, w_adj;
    logic [W-1:0]      r_op, w_op_nx;
    logic [c_cw-1:0]   r_cnt, w_cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_bcd   <= w_bcd_nx;
            r_op    <= w_op_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_bcd_nx   = r_bcd;
        w_op_nx    = r_op;
        w_cnt_nx   = r_cnt;
        w_adj      = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nx    = operand;
                    w_bcd_nx   = '0;
                    w_cnt_nx   = c_cw'(W);
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_bcd_nx = {w_adj[4*NB-2:0], r_op[W-1]};
                w_op_nx  = {r_op[W-2:0], 1'b0};
                w_cnt_nx = r_cnt - c_cw'(1);
                if (r_cnt == c_cw'(1)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/complement_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : complement_display_ctrl
// Description : Switch value viewer (orig/ones/twos/signed) on 7-seg digits.
// Revision    : 1.0 - initial release
// ============================================================================
module complement_display_ctrl
    import complement_display_pkg::*;
#(
    parameter int W            = 10,
    parameter int DIGITS       = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLANK_LZ     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        sw,
    input  logic                key_mode_n,
    output logic [7*DIGITS-1:0] hex,
    output logic [1:0]          mode,
    output logic                busy,
    output logic                overflow
);

    localparam int c_nb  = bcd_nibbles(W);
    localparam int c_nd  = (c_nb > DIGITS) ? c_nb : DIGITS;
    localparam int c_dbw = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_dbw-1:0] c_db_max = c_dbw'(DEBOUNCE_CYC - 1);

    logic [W-1:0]        r_sw_s1, r_sw_s2, r_last_v, w_v;
    logic                r_key_s1, r_key_s2, r_db_level, w_press;
    logic [c_dbw-1:0]    r_db_cnt;
    mode_t               r_mode, r_last_mode, r_cap_mode;
    logic                r_pend, r_cap_neg, w_neg, w_req, w_start;
    logic                w_busy, w_done, w_ovf, r_ovf;
    logic [4*c_nb-1:0]   w_bcd;
    logic [3:0]          w_nib [c_nd];
    logic [7*DIGITS-1:0] w_hex, r_hex;
    int                  w_avail, w_msd;

    // Switch synchroniser keeps sampling through reset so the first
    // conversion after release already sees the real switch value.
    always_ff @(posedge clk) begin
        r_sw_s1 <= sw;
        r_sw_s2 <= r_sw_s1;
    end

    assign w_press = (r_key_s2 != r_db_level) && (r_db_cnt == c_db_max) && !r_key_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_mode     <= MODE_ORIG;
        end else begin
            r_key_s1 <= key_mode_n;
            r_key_s2 <= r_key_s1;
            if (r_key_s2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_max) begin
                r_db_level <= r_key_s2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_press) begin
                r_mode <= mode_t'(r_mode + 2'd1);
            end
        end
    end

    always_comb begin
        w_neg = 1'b0;
        w_v   = r_sw_s2;
        case (r_mode)
            MODE_ONES: w_v = ~r_sw_s2;
            MODE_TWOS: w_v = ~r_sw_s2 + W'(1);
            MODE_SIGNED: begin
                w_neg = r_sw_s2[W-1];
                if (w_neg) begin
                    w_v = ~r_sw_s2 + W'(1);
                end
            end
            default: w_v = r_sw_s2;
        endcase
    end

    // A differing pair stays visible while busy, so it is serviced afterwards.
    assign w_req   = r_pend || (r_mode != r_last_mode) || (w_v != r_last_v);
    assign w_start = w_req && !w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b1;
            r_last_mode <= MODE_ORIG;
            r_last_v    <= '0;
            r_cap_mode  <= MODE_ORIG;
            r_cap_neg   <= 1'b0;
            r_hex       <= {DIGITS{SEG_BLANK}};
            r_ovf       <= 1'b0;
        end else begin
            if (w_start) begin
                r_pend      <= 1'b0;
                r_last_mode <= r_mode;
                r_last_v    <= w_v;
                r_cap_mode  <= r_mode;
                r_cap_neg   <= w_neg;
            end
            if (w_done) begin
                r_hex <= w_hex;
                r_ovf <= w_ovf;
            end
        end
    end

    bin2bcd_seq #(
        .W  (W),
        .NB (c_nb)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .operand (w_v),
        .busy    (w_busy),
        .done    (w_done),
        .bcd     (w_bcd)
    );

    for (genvar gi = 0; gi < c_nd; gi++) begin : g_nib
        if (gi < c_nb) begin : g_bcd
            assign w_nib[gi] = w_bcd[4*gi +: 4];
        end else begin : g_pad
            assign w_nib[gi] = 4'd0;
        end
    end

    always_comb begin
        w_avail = (r_cap_mode == MODE_SIGNED) ? DIGITS - 1 : DIGITS;
        w_ovf   = 1'b0;
        w_msd   = 0;
        w_hex   = {DIGITS{SEG_BLANK}};
        for (int i = 0; i < c_nd; i++) begin
            if (w_nib[i] != 4'd0) begin
                w_msd = i;
                if (i >= w_avail) begin
                    w_ovf = 1'b1;
                end
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ovf) begin
                w_hex[7*i +: 7] = SEG_DASH;
            end else if (i < w_avail) begin
                w_hex[7*i +: 7] = (BLANK_LZ != 0 && i > w_msd) ? SEG_BLANK : seg_digit(w_nib[i]);
            end else begin
                w_hex[7*i +: 7] = r_cap_neg ? SEG_DASH : SEG_BLANK;
            end
        end
    end

    assign hex      = r_hex;
    assign mode     = r_mode;
    assign busy     = w_busy;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_complement_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_complement_display_ctrl
// Description : Self-checking bench with a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complement_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  sw;
    logic        key;
    logic [27:0] hex;
    logic [1:0]  mode;
    logic        busy, ovf;
    logic [13:0] sw14;
    logic        key14;
    logic [27:0] hex14;
    logic [1:0]  mode14;
    logic        busy14, ovf14;

    int checks = 0;
    int errors = 0;
    int exp_mode = 0;
    int rises = 0;
    logic busy_q = 1'b0;

    always #5 clk = ~clk;

    complement_display_ctrl #(.W(10), .DIGITS(4), .DEBOUNCE_CYC(8), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .key_mode_n(key),
        .hex(hex), .mode(mode), .busy(busy), .overflow(ovf));

    complement_display_ctrl #(.W(14), .DIGITS(4), .DEBOUNCE_CYC(8), .BLANK_LZ(1)) dut14 (
        .clk(clk), .rst_n(rst_n), .sw(sw14), .key_mode_n(key14),
        .hex(hex14), .mode(mode14), .busy(busy14), .overflow(ovf14));

    always @(negedge clk) begin
        if (busy && !busy_q) rises++;
        busy_q <= busy;
    end

    function automatic logic [6:0] seg_tab(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    // Expected {overflow, hex} from the decimal value of the chosen interpretation.
    function automatic logic [28:0] model(input int w, input int md, input int swv);
        int mask, val, avail, lim, p;
        bit neg;
        logic [27:0] hx;
        logic ov;
        mask = (1 << w) - 1;
        neg  = 1'b0;
        case (md)
            0: val = swv & mask;
            1: val = (~swv) & mask;
            2: val = (-swv) & mask;
            default: begin
                neg = ((swv >> (w - 1)) & 1) == 1;
                val = neg ? ((-swv) & mask) : (swv & mask);
            end
        endcase
        avail = (md == 3) ? 3 : 4;
        lim = 1;
        for (int i = 0; i < avail; i++) lim = lim * 10;
        ov = (val >= lim);
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (ov) hx[7*i +: 7] = 7'h3F;
            else if (i < avail) hx[7*i +: 7] = (i > 0 && val < p) ? 7'h7F : seg_tab((val / p) % 10);
            else hx[7*i +: 7] = neg ? 7'h3F : 7'h7F;
            p = p * 10;
        end
        return {ov, hx};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        logic [28:0] e;
        e = model(10, exp_mode, int'(sw));
        check({tag, "_hex"}, {4'h0, hex}, {4'h0, e[27:0]});
        check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, e[28]});
        check({tag, "_mode"}, {30'h0, mode}, exp_mode);
    endtask

    task automatic press();
        key = 1'b0;
        cycles(10);
        key = 1'b1;
        cycles(12);
        exp_mode = (exp_mode + 1) % 4;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            cycles(1);
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        logic [28:0] e;
        int r0;
        rst_n = 1'b0; sw = 10'd13; key = 1'b1; sw14 = 14'd16383; key14 = 1'b1;
        cycles(4);
        check("rst_hex", {4'h0, hex}, 32'h0FFFFFFF);
        check("rst_mode", {30'h0, mode}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_ovf", {31'h0, ovf}, 0);
        rst_n = 1'b1;
        cycles(1);
        check("cap_busy", {31'h0, busy}, 1);
        cycles(10);
        check("pre_done_busy", {31'h0, busy}, 1);
        check("pre_done_hex", {4'h0, hex}, 32'h0FFFFFFF);
        cycles(1);
        check("done_busy", {31'h0, busy}, 0);
        check("sw13_const", {4'h0, hex}, {4'h0, 7'h7F, 7'h7F, 7'h79, 7'h30});
        check_disp("sw13_orig");

        for (int k = 0; k < 3; k++) begin
            press();
            cycles(20);
            check_disp("sw13_press");
        end

        sw = 10'd1023; cycles(30); check_disp("signed_m1");
        sw = 10'd512;  cycles(30); check_disp("signed_m512");
        sw = 10'd0;
        for (int k = 0; k < 3; k++) begin
            press();
            cycles(20);
        end
        check_disp("twos_zero");

        e = model(14, 0, 16383);
        check("w14_ovf_hex", {4'h0, hex14}, {4'h0, e[27:0]});
        check("w14_ovf", {31'h0, ovf14}, 1);
        sw14 = 14'd9999; cycles(30);
        e = model(14, 0, 9999);
        check("w14_9999_hex", {4'h0, hex14}, {4'h0, e[27:0]});
        check("w14_9999_ovf", {31'h0, ovf14}, 0);

        key = 1'b0; cycles(5); key = 1'b1; cycles(20);
        check("glitch_mode", {30'h0, mode}, exp_mode);
        key = 1'b0; cycles(10); key = 1'b1; cycles(3); key = 1'b0; cycles(20); key = 1'b1; cycles(20);
        exp_mode = (exp_mode + 1) % 4;
        cycles(20);
        check_disp("bounce");

        rst_n = 1'b0; sw = 10'd13; exp_mode = 0;
        cycles(3);
        r0 = rises;
        rst_n = 1'b1;
        cycles(3);
        sw = 10'd200;
        wait_idle("t5a");
        e = model(10, 0, 13);
        check("t5_first", {4'h0, hex}, {4'h0, e[27:0]});
        cycles(11);
        check("t5_hold", {4'h0, hex}, {4'h0, e[27:0]});
        check("t5_busy2", {31'h0, busy}, 1);
        cycles(1);
        check_disp("t5_second");
        check("t5_rises", rises - r0, 2);

        sw = 10'd777;
        cycles(5);
        rst_n = 1'b0;
        #1;
        check("t6_hex", {4'h0, hex}, 32'h0FFFFFFF);
        check("t6_busy", {31'h0, busy}, 0);
        exp_mode = 0;
        cycles(2);
        rst_n = 1'b1;
        cycles(14);
        check_disp("t6_refill");

        for (int k = 0; k < 20; k++) begin
            sw = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) press();
            cycles(30);
            check_disp("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
